button_events: RTL and testbench
================================

# button_events

Input-side counterpart to the LED drivers: samples up to N raw board push-buttons, synchronises and debounces each one, and turns stable transitions into a queue of press, release and long-press events. Downstream logic (pattern/speed control) pops events over a valid/ready handshake. Debounced levels are also exported for direct use.

## Interface
- N_BUTTONS, 4: number of button channels (1..8).
- DEBOUNCE_CYCLES, 120000: consecutive stable cycles needed to accept a level change (10 ms at 12 MHz); ≥2.
- LONG_CYCLES, 12000000: cycles a press must be held to emit a long-press event (1 s); > DEBOUNCE_CYCLES.
- FIFO_DEPTH, 4: event queue entries; power of two, ≥2.

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- btn_n  in  N_BUTTONS  raw buttons, active-low (pulled up), asynchronous to clk.
- pressed  out  N_BUTTONS  debounced level, 1 = held.
- ev_valid  out  1  event available at head of queue.
- ev_ready  in  1  consumer accepts head event when ev_valid & ev_ready at a rising edge.
- ev_code  out  2  1 = press, 2 = release, 3 = long-press; 0 never emitted.
- ev_idx  out  3  channel number of head event (upper bits 0 when N_BUTTONS < 8).
- ev_drop  out  1  one-cycle pulse: an event was lost.

## Operation
- Reset (async assert, sync-safe release): synchroniser flops = 1 (released), all counters 0, all FSMs RELEASED, pending bits clear, FIFO empty; pressed = 0, ev_valid = 0, ev_code = 0, ev_idx = 0, ev_drop = 0.
- Per channel: 2-flop synchroniser on btn_n; s = inverted synchroniser output (1 = pushed).
- Debounce counter: while s ≠ pressed, increment; any cycle with s = pressed clears it to 0. When the counter would reach DEBOUNCE_CYCLES, pressed toggles and the counter clears. Counter never wraps.
- Per-channel FSM:
  - RELEASED: accepted press -> PRESSED, raise press event, clear long counter.
  - PRESSED: long counter increments each cycle; at LONG_CYCLES -> LONG_HELD, raise long-press event. Accepted release -> RELEASED, raise release event.
  - LONG_HELD: long counter frozen; accepted release -> RELEASED, raise release event.
  - Long-press fires at most once per press; release always follows it.
- Event raising sets the channel's one-entry pending register {code}. If pending is already set, the new event is discarded and ev_drop pulses the next cycle.
- Arbiter: each cycle, if FIFO not full (or a pop occurs the same cycle), moves the lowest-index pending channel into the FIFO and clears that pending bit. One push per cycle maximum.
- FIFO: show-ahead; ev_code/ev_idx reflect head while ev_valid = 1; hold value 0 while empty. Simultaneous push and pop on full FIFO is allowed (count unchanged).
- Consumer stalled: events accumulate in FIFO, then in pending registers; further events on a channel with pending set are dropped with ev_drop. Nothing already queued is ever lost or reordered.

## Timing
- Raw edge stable from edge 0: s changes after edge 2; pressed changes at edge 2 + DEBOUNCE_CYCLES.
- Pending set at the same edge pressed changes; pushed to FIFO at next edge; ev_valid high after edge 3 + DEBOUNCE_CYCLES (empty FIFO, no contention).
- Long-press event pending LONG_CYCLES edges after pressed rises; visible one edge later.
- Same-cycle events on channels i < j: i appears first, j one cycle later.
- Bounce shorter than DEBOUNCE_CYCLES produces no level change and no event.
- ev_drop: exactly one cycle per lost event, registered.
- rst_n asserted mid-press: all state cleared immediately; no release event emitted; after release of reset a still-held button yields a fresh press after the normal debounce delay.

## Test plan
(DEBOUNCE_CYCLES=4, LONG_CYCLES=20, FIFO_DEPTH=4, N_BUTTONS=4, ev_ready=1 unless stated.)
- btn_n[0] low for 30 cycles then high -> pressed[0] rises at edge 6; events (idx0,press) at edge 7, (idx0,long) 20 cycles after pressed, (idx0,release) after debounce of release; no others.
- btn_n[1] toggles every 3 cycles for 40 cycles, then held high -> pressed[1] stays 0, ev_valid never asserts.
- btn_n[2] and btn_n[3] fall on the same edge -> press idx2 then press idx3 on consecutive cycles.
- ev_ready=0; 5 buttons events from short presses on ch0..3 -> FIFO holds 4, pending holds rest; extra event on a pending channel pulses ev_drop once; raising ev_ready drains all survivors in raise order.
- Assert rst_n low while ch0 in LONG_HELD -> all outputs 0 asynchronously; button still held after release -> single press event after 7 edges.
- Full FIFO with ev_ready=1 and new pending push same cycle -> count stays 4, no drop, order preserved.

Source files
------------

// File: rtl/button_events.sv
// rtl/button_events.sv - debounced push-button press/release/long-press event queue
//
// Purpose:
//   Synchronises and debounces up to N_BUTTONS raw active-low buttons.
//   Stable transitions are turned into press, release and long-press events.
//   Each channel parks a raised event in a one-entry pending slot.
//   A lowest-index-first arbiter moves pending events into a show-ahead FIFO.
//   The consumer pops that FIFO over a valid/ready handshake.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   btn_n     in   raw buttons, active-low, asynchronous to clk
//   pressed   out  debounced level per channel, 1 = held
//   ev_valid  out  event available at head of queue
//   ev_ready  in   consumer takes head event when ev_valid & ev_ready
//   ev_code   out  1 = press, 2 = release, 3 = long-press (0 while empty)
//   ev_idx    out  channel of head event (0 while empty)
//   ev_drop   out  one-cycle pulse per lost event
module button_events #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] btn_n,
  output logic [N_BUTTONS-1:0] pressed,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [1:0]           ev_code,
  output logic [2:0]           ev_idx,
  output logic                 ev_drop
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int LGW = $clog2(LONG_CYCLES);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LGW-1:0] LG_LAST = LGW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] EV_PRESS   = 2'd1;
  localparam logic [1:0] EV_RELEASE = 2'd2;
  localparam logic [1:0] EV_LONG    = 2'd3;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2
  } state_e;

  logic [N_BUTTONS-1:0] sync1_q, sync2_q;
  logic [N_BUTTONS-1:0] pressed_q;
  logic [N_BUTTONS-1:0] pend_valid_q;
  logic [1:0]           pend_code_q [N_BUTTONS];
  logic [DBW-1:0]       db_cnt_q    [N_BUTTONS];
  logic [LGW-1:0]       long_cnt_q  [N_BUTTONS];
  state_e               state_q     [N_BUTTONS];

  // FIFO entry is {idx[2:0], code[1:0]}
  logic [4:0]           fifo_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;

  // Drops not yet signalled; lets simultaneous losses each get their own pulse
  logic [3:0]           drop_cnt_q;
  logic                 drop_q;

  logic [N_BUTTONS-1:0] btn_s, accept, raise, grant, drop;
  logic [1:0]           raise_code [N_BUTTONS];
  logic                 push, pop, fifo_full, fifo_empty;
  logic [4:0]           push_data;
  logic [4:0]           drop_total, drop_left;

  // Per-channel debounce acceptance and event generation
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      btn_s[i]      = ~sync2_q[i];
      accept[i]     = (btn_s[i] != pressed_q[i]) && (db_cnt_q[i] == DB_LAST);
      raise[i]      = 1'b0;
      raise_code[i] = 2'd0;
      if (accept[i]) begin
        raise[i]      = 1'b1;
        raise_code[i] = pressed_q[i] ? EV_RELEASE : EV_PRESS;
      end else if ((state_q[i] == ST_PRESSED) && (long_cnt_q[i] == LG_LAST)) begin
        raise[i]      = 1'b1;
        raise_code[i] = EV_LONG;
      end
    end
  end

  // Arbiter: one pending channel per cycle, lowest index wins
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_C);
    pop        = ~fifo_empty & ev_ready;
    push       = 1'b0;
    grant      = '0;
    push_data  = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (!push && pend_valid_q[i] && (!fifo_full || pop)) begin
        push      = 1'b1;
        grant[i]  = 1'b1;
        push_data = {3'(i), pend_code_q[i]};
      end
    end
    // A slot being moved out this cycle can take the new event without loss
    drop       = raise & pend_valid_q & ~grant;
    drop_total = {1'b0, drop_cnt_q};
    for (int i = 0; i < N_BUTTONS; i++) begin
      drop_total = drop_total + 5'(drop[i]);
    end
    drop_left = (drop_total == '0) ? 5'd0 : drop_total - 5'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      pressed_q    <= '0;
      pend_valid_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        pend_code_q[i] <= '0;
        db_cnt_q[i]    <= '0;
        long_cnt_q[i]  <= '0;
        state_q[i]     <= ST_RELEASED;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;

      for (int i = 0; i < N_BUTTONS; i++) begin
        if ((btn_s[i] == pressed_q[i]) || accept[i]) begin
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
        end

        if (accept[i]) begin
          pressed_q[i] <= ~pressed_q[i];
        end

        case (state_q[i])
          ST_RELEASED: begin
            if (accept[i]) begin
              state_q[i]    <= ST_PRESSED;
              long_cnt_q[i] <= '0;
            end
          end
          ST_PRESSED: begin
            if (accept[i]) begin
              state_q[i] <= ST_RELEASED;
            end else if (long_cnt_q[i] == LG_LAST) begin
              state_q[i] <= ST_LONG_HELD;
            end else begin
              long_cnt_q[i] <= long_cnt_q[i] + LGW'(1);
            end
          end
          ST_LONG_HELD: begin
            if (accept[i]) begin
              state_q[i] <= ST_RELEASED;
            end
          end
          default: state_q[i] <= ST_RELEASED;
        endcase

        if (raise[i] && (!pend_valid_q[i] || grant[i])) begin
          pend_valid_q[i] <= 1'b1;
          pend_code_q[i]  <= raise_code[i];
        end else if (grant[i]) begin
          pend_valid_q[i] <= 1'b0;
        end
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CW'(1);
      end

      drop_q     <= (drop_total != '0);
      drop_cnt_q <= (drop_left > 5'd15) ? 4'd15 : drop_left[3:0];
    end
  end

  // Storage needs no reset: entries are only read while count_q says valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_data;
    end
  end

  assign pressed  = pressed_q;
  assign ev_valid = ~fifo_empty;
  assign ev_code  = fifo_empty ? 2'd0 : fifo_q[rd_ptr_q][1:0];
  assign ev_idx   = fifo_empty ? 3'd0 : fifo_q[rd_ptr_q][4:2];
  assign ev_drop  = drop_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - self-checking bench for button_events
module tb_button_events;

  localparam int N     = 4;
  localparam int DEB   = 4;
  localparam int LONG  = 20;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_n;
  logic [N-1:0] pressed;
  logic         ev_valid;
  logic         ev_ready;
  logic [1:0]   ev_code;
  logic [2:0]   ev_idx;
  logic         ev_drop;

  typedef struct packed {
    logic [2:0] idx;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic [3:0] exp_pressed;
    int         n_ev;
    ev_t        ev0;
    ev_t        ev1;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[8];
  int   checks    = 0;
  int   errors    = 0;
  int   drop_seen = 0;
  logic any_p, any_v;

  always #5 clk = ~clk;

  button_events #(
    .N_BUTTONS(N),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_n(btn_n),
    .pressed(pressed),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_code(ev_code),
    .ev_idx(ev_idx),
    .ev_drop(ev_drop)
  );

  function automatic ev_t mk_ev(input int idx, input int code);
    ev_t e;
    e.idx  = 3'(idx);
    e.code = 2'(code);
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [3:0] btn, input int hold, input logic [3:0] exp_p,
                                  input int n, input int i0, input int c0, input int i1, input int c1);
    vec_t v;
    v.btn         = btn;
    v.hold        = hold;
    v.exp_pressed = exp_p;
    v.n_ev        = n;
    v.ev0         = mk_ev(i0, c0);
    v.ev1         = mk_ev(i1, c1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_ev(input int idx, input int code);
    sb.push_back(mk_ev(idx, code));
  endtask

  // Sampled at the falling edge: a handshake seen here completes at the next rising edge
  task automatic mon();
    ev_t e;
    if (ev_drop) drop_seen++;
    if (ev_valid && ev_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got idx=%0d code=%0d want none", ev_idx, ev_code);
      end else begin
        e = sb.pop_front();
        if (ev_idx !== e.idx || ev_code !== e.code) begin
          errors++;
          $display("FAIL sb_event got idx=%0d code=%0d want idx=%0d code=%0d",
                   ev_idx, ev_code, e.idx, e.code);
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk_vec(4'b1011, 10, 4'b0100, 1, 2, 1, 0, 0);
    vecs[1] = mk_vec(4'b1111, 10, 4'b0000, 1, 2, 2, 0, 0);
    vecs[2] = mk_vec(4'b0011, 10, 4'b1100, 2, 2, 1, 3, 1);
    vecs[3] = mk_vec(4'b1111, 10, 4'b0000, 2, 2, 2, 3, 2);
    vecs[4] = mk_vec(4'b1101,  3, 4'b0000, 0, 0, 0, 0, 0);
    vecs[5] = mk_vec(4'b1111, 10, 4'b0000, 0, 0, 0, 0, 0);
    vecs[6] = mk_vec(4'b1101,  4, 4'b0000, 1, 1, 1, 0, 0);
    vecs[7] = mk_vec(4'b1111, 12, 4'b0000, 1, 1, 2, 0, 0);

    // Reset state
    rst_n    = 1'b0;
    btn_n    = '1;
    ev_ready = 1'b1;
    #2;
    chk("rst_outputs", {pressed, ev_valid, ev_code, ev_idx, ev_drop}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(3);
    chk("rst_idle", {pressed, ev_valid, ev_code, ev_idx, ev_drop}, 0);

    // Single press with exact latencies, long-press, then release
    btn_n = 4'b1110;
    expect_ev(0, 1);
    expect_ev(0, 3);
    tick(5);
    chk("a_pressed_e5", pressed, 4'b0000);
    tick(1);
    chk("a_pressed_e6", pressed, 4'b0001);
    chk("a_valid_e6", ev_valid, 0);
    tick(1);
    chk("a_press_e7", {ev_valid, ev_idx, ev_code}, {1'b1, 3'd0, 2'd1});
    tick(19);
    chk("a_valid_e26", ev_valid, 0);
    tick(1);
    chk("a_long_e27", {ev_valid, ev_idx, ev_code}, {1'b1, 3'd0, 2'd3});
    tick(3);
    btn_n = 4'b1111;
    expect_ev(0, 2);
    tick(6);
    chk("a_released", pressed, 4'b0000);
    tick(1);
    chk("a_release_ev", {ev_valid, ev_idx, ev_code}, {1'b1, 3'd0, 2'd2});
    tick(3);
    chk("a_sb_empty", sb.size(), 0);

    // Bounce: ch1 toggles every 3 cycles, never stable long enough
    any_p = 1'b0;
    any_v = 1'b0;
    for (int k = 0; k < 14; k++) begin
      btn_n[1] = ~btn_n[1];
      for (int j = 0; j < 3; j++) begin
        tick(1);
        any_p |= pressed[1];
        any_v |= ev_valid;
      end
    end
    btn_n = 4'b1111;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      any_p |= pressed[1];
      any_v |= ev_valid;
    end
    chk("b_no_press", any_p, 0);
    chk("b_no_event", any_v, 0);

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      btn_n = vecs[v].btn;
      if (vecs[v].n_ev > 0) sb.push_back(vecs[v].ev0);
      if (vecs[v].n_ev > 1) sb.push_back(vecs[v].ev1);
      tick(vecs[v].hold);
      chk($sformatf("c_vec%0d_pressed", v), pressed, vecs[v].exp_pressed);
    end
    tick(4);
    chk("c_sb_empty", sb.size(), 0);

    // Stalled consumer: FIFO fills, pending holds press2, release2 is lost
    ev_ready = 1'b0;
    btn_n = 4'b1110; expect_ev(0, 1); tick(8);
    btn_n = 4'b1111; expect_ev(0, 2); tick(8);
    btn_n = 4'b1101; expect_ev(1, 1); tick(8);
    btn_n = 4'b1111; expect_ev(1, 2); tick(8);
    btn_n = 4'b1011; expect_ev(2, 1); tick(8);
    chk("d_head_held", {ev_valid, ev_idx, ev_code}, {1'b1, 3'd0, 2'd1});
    chk("d_no_drop_yet", drop_seen, 0);
    btn_n = 4'b1111;
    tick(6);
    chk("d_drop_pulse", ev_drop, 1);
    tick(1);
    chk("d_drop_one_cycle", ev_drop, 0);
    tick(4);
    chk("d_drop_count", drop_seen, 1);
    chk("d_pressed_clear", pressed, 4'b0000);
    // First pop happens with a full FIFO and press2 pending: push and pop together
    ev_ready = 1'b1;
    tick(8);
    chk("d_drained", sb.size(), 0);
    chk("d_valid_low", ev_valid, 0);
    chk("d_no_extra_drop", drop_seen, 1);

    // Reset while ch0 is long-held, button kept down through reset
    ev_ready = 1'b0;
    btn_n = 4'b1110;
    expect_ev(0, 1);
    expect_ev(0, 3);
    tick(28);
    chk("e_long_held_pre", {pressed[0], ev_valid, ev_idx, ev_code}, {1'b1, 1'b1, 3'd0, 2'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("e_async_clear", {pressed, ev_valid, ev_code, ev_idx, ev_drop}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    expect_ev(0, 1);
    tick(6);
    chk("e_pressed_again", pressed, 4'b0001);
    chk("e_valid_e6", ev_valid, 0);
    tick(1);
    chk("e_fresh_press", {ev_valid, ev_idx, ev_code}, {1'b1, 3'd0, 2'd1});
    expect_ev(0, 3);
    tick(22);
    btn_n = 4'b1111;
    expect_ev(0, 2);
    tick(10);
    chk("e_sb_empty", sb.size(), 0);
    chk("e_drop_none", drop_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
